// File: rtl/mux_scan_nto1.sv
// N-channel registered multiplexer with manual select and a dwell-paced scan sequencer.
// Optional MUX_PARITY_EN adds y_par, the XOR-reduction of the captured sample.
module mux_scan_nto1 #(
  parameter int N_CH    = 16,
  parameter int W       = 1,
  parameter int SEL_W   = $clog2(N_CH),
  parameter int DWELL_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH*W-1:0]   din,
  input  logic                mode,
  input  logic                en,
  input  logic [SEL_W-1:0]    sel,
  input  logic                start,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [W-1:0]        y,
  output logic [SEL_W-1:0]    y_ch,
  output logic                y_valid,
  input  logic                y_ready,
  output logic                sel_err,
  output logic                frame_done
`ifdef MUX_PARITY_EN
  ,
  output logic                y_par
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DWELL} state_t;

  localparam logic [SEL_W:0]   LP_N    = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LP_LAST = SEL_W'(N_CH - 1);

  state_t               r_state, w_state_nxt;
  logic [SEL_W-1:0]     r_ch;
  logic [DWELL_W-1:0]   r_cnt;
  logic [W-1:0]         r_y;
  logic [SEL_W-1:0]     r_y_ch;
  logic                 r_valid;
  logic                 r_sel_err;
  logic                 r_frame_done;

  logic                 w_free;
  logic                 w_cap_man;
  logic                 w_cap_scan;
  logic                 w_cap;
  logic                 w_oor;
  logic                 w_last;
  logic [SEL_W-1:0]     w_idx;
  logic [W-1:0]         w_data;

  assign w_free     = !r_valid || y_ready;
  assign w_cap_man  = (r_state == IDLE) && !mode && en && w_free;
  assign w_cap_scan = (r_state == SCAN) && mode && w_free;
  assign w_cap      = w_cap_man || w_cap_scan;
  assign w_idx      = (r_state == SCAN) ? r_ch : sel;
  assign w_oor      = {1'b0, w_idx} >= LP_N;
  assign w_last     = (r_ch == LP_LAST);

  // Out-of-range indices fall through to zero, which is also the sel_err sample value.
  always_comb begin
    w_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_idx == SEL_W'(k)) w_data = din[k*W +: W];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (mode && start) w_state_nxt = SCAN;
      SCAN: begin
        if (!mode)                         w_state_nxt = IDLE;
        else if (w_free && dwell != '0)    w_state_nxt = DWELL;
      end
      DWELL: begin
        if (!mode)            w_state_nxt = IDLE;
        else if (r_cnt == '0) w_state_nxt = SCAN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ch         <= '0;
      r_cnt        <= '0;
      r_y          <= '0;
      r_y_ch       <= '0;
      r_valid      <= 1'b0;
      r_sel_err    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: r_ch <= '0;
        SCAN: begin
          if (!mode) begin
            r_ch <= '0;
          end else if (w_free) begin
            r_ch <= w_last ? '0 : r_ch + SEL_W'(1);
            if (dwell != '0) r_cnt <= dwell - DWELL_W'(1);
          end
        end
        DWELL: begin
          if (!mode)              r_ch  <= '0;
          else if (r_cnt != '0)   r_cnt <= r_cnt - DWELL_W'(1);
        end
        default: r_ch <= '0;
      endcase

      // Capture and accept may coincide; the new sample then replaces the accepted one.
      if (w_cap) begin
        r_y     <= w_data;
        r_y_ch  <= w_idx;
        r_valid <= 1'b1;
      end else if (y_ready) begin
        r_valid <= 1'b0;
      end
      r_sel_err    <= w_cap_man && w_oor;
      r_frame_done <= w_cap_scan && w_last;
    end
  end

`ifdef MUX_PARITY_EN
  logic r_par;
  always_ff @(posedge clk) begin
    if (rst)        r_par <= 1'b0;
    else if (w_cap) r_par <= ^w_data;
  end
  assign y_par = r_par;
`endif

  assign y          = r_y;
  assign y_ch       = r_y_ch;
  assign y_valid    = r_valid;
  assign sel_err    = r_sel_err;
  assign frame_done = r_frame_done;

endmodule

// File: doc/mux_scan_nto1.md
Name: mux_scan_nto1

Overview:
- Parametrised N-channel, W-bit-wide registered multiplexer.
- Two operating modes:
  - Manual mode: an external select picks the channel.
  - Scan mode: an internal sequencer steps through channels 0..N_CH-1 with a programmable dwell between samples.
- Output is a registered sample plus its channel tag, delivered over a valid/ready handshake.
- Sits between banks of switch/sensor inputs and downstream display or serial logic. Generalises the fixed 16-to-1 single-bit selector.

Parameters:
- N_CH, 16, number of input channels (2..256).
- W, 1, bits per channel.
- SEL_W, $clog2(N_CH), channel index width (derived; do not override).
- DWELL_W, 8, width of the dwell count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  N_CH*W  packed channel data; channel k occupies din[k*W +: W].
- mode  input  1  0 = manual, 1 = scan.
- en  input  1  manual-mode capture enable.
- sel  input  SEL_W  manual-mode channel select.
- start  input  1  single-cycle pulse that begins scanning (only honoured when mode=1).
- dwell  input  DWELL_W  idle cycles inserted after each scan capture.
- y  output  W  registered sample.
- y_ch  output  SEL_W  channel index of y.
- y_valid  output  1  y/y_ch hold a sample.
- y_ready  input  1  downstream accepts the sample.
- sel_err  output  1  one-cycle pulse: manual sel >= N_CH.
- frame_done  output  1  one-cycle pulse: last channel of a scan frame captured.

Behaviour:
- Reset values: y=0, y_ch=0, y_valid=0, sel_err=0, frame_done=0; FSM=IDLE, ch=0, cnt=0.
- rst mid-operation takes priority over all other inputs. It aborts any scan or dwell and drops y_valid on the following edge.
- Slot free condition: free = !y_valid || y_ready. A capture may only occur when free=1.
- While y_valid=1 and y_ready=0, y, y_ch and y_valid hold stable.
- Acceptance:
  - A sample is accepted on a cycle with y_valid && y_ready.
  - If no new capture occurs in that cycle, y_valid falls on the next edge.
  - Simultaneous accept and capture keeps y_valid=1 and loads the new data (full throughput).
- Latency: 1 cycle from the capturing edge. din is sampled at the same edge that loads y.
- FSM states: IDLE, SCAN, DWELL.
- IDLE with mode=0 (manual):
  - If en && free, capture din[sel] into y, set y_ch=sel, y_valid=1.
  - If sel >= N_CH (only possible when N_CH is not a power of 2): y=0, y_ch=sel, y_valid=1, and sel_err pulses high in the same cycle as y_valid rises.
- IDLE with mode=1 && start: go to SCAN with ch=0. start is ignored when mode=0 or when not in IDLE.
- SCAN, when free:
  - Capture din[ch] into y, set y_ch=ch, y_valid=1.
  - If ch==N_CH-1: frame_done pulses with that capture and ch wraps to 0; otherwise ch=ch+1.
  - If dwell!=0: load cnt=dwell-1 and go to DWELL. If dwell==0: stay in SCAN.
- DWELL:
  - If cnt==0, go to SCAN; else cnt=cnt-1.
  - Exactly dwell cycles are spent in DWELL before the next capture opportunity.
  - dwell is sampled only at capture time.
- mode falling to 0 while in SCAN or DWELL:
  - Return to IDLE at the next edge and set ch=0.
  - Any sample already in y is retained until accepted.
  - No capture occurs on the exit edge.
- Scanning is continuous, frame after frame, until mode=0 or rst.
- Downstream stall in SCAN: the sequencer waits (ch frozen). No channel is skipped.

Optional Feature:
- Macro: MUX_PARITY_EN.
- Defined:
  - Adds output y_par (1 bit), the even parity (XOR-reduction) of the captured data.
  - Registered with y, with identical latency and hold behaviour; reset value 0.
  - On sel_err captures, y_par=0.
- Undefined: the y_par port and its logic are absent; all other behaviour is identical.

Test Plan:
- Manual capture, N_CH=16, W=1: din=16'hA5C3, sel=4'd0..15, en=1, y_ready=1 → one cycle after each sel, y=din[sel] (sel=0→1, sel=2→0, sel=15→1), y_ch=sel, y_valid continuously 1.
- Backpressure: manual mode, sel=5, capture, then y_ready=0 for 4 cycles while sel changes to 6 → y/y_ch hold channel 5 data; with y_ready=1 the next edge loads channel 6.
- Scan with dwell, N_CH=4, W=8: din={8'h44,8'h33,8'h22,8'h11}, dwell=2, start pulse, y_ready=1 → y sequence 11,22,33,44,11… one capture every 3 cycles; frame_done pulses with the 8'h44 capture.
- Scan with dwell=0 and y_ready toggled 1,0,1,0 → captures only in free cycles; y_ch strictly 0,1,2,3,0 with no skips.
- Out-of-range select, N_CH=10: manual sel=4'd12 → y=0, y_ch=12, y_valid=1, sel_err=1 for one cycle.
- Reset mid-scan: assert rst during DWELL at ch=2 → next edge y_valid=0, FSM IDLE; a new start restarts at y_ch=0.
- Parity build (MUX_PARITY_EN defined), W=8: capture 8'h07 → y_par=1; capture 8'h03 → y_par=0.
